// File: rtl/wb_cmd_master.sv
// Wishbone classic single-cycle master: one command in, one bus cycle, one response out.
// Optional bus-cycle timeout is enabled by defining WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              wb_clk,
    input  logic              wb_rst_n,
    // Command and response handshakes: a transfer happens on a rising edge where
    // valid and ready are both high; the producer holds valid and payload until then.
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_status,
    output logic              wb_cycle,
    output logic              wb_strobe,
    output logic              wb_we,
    output logic [3:0]        wb_sel,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [31:0]       wb_wdata,
    output logic [2:0]        wb_cti,
    output logic [1:0]        wb_bte,
    input  logic              wb_ack,
    input  logic              wb_err,
    input  logic              wb_rty,
    input  logic [31:0]       wb_rdata,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    logic       rst_sync;
    logic       term;
    logic       tmo_hit;
    logic [1:0] term_status;

    // Release of reset is seen by the handshake one edge late, so the first
    // accept lands on the second rising edge after wb_rst_n goes high.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) rst_sync <= 1'b0;
        else           rst_sync <= 1'b1;
    end

    assign req_ready = rst_sync && (state == IDLE);
    assign dbg_state = state;
    assign wb_cti    = 3'b000;
    assign wb_bte    = 2'b00;
    assign term      = wb_ack || wb_err || wb_rty;

    always_comb begin
        term_status = 2'b00;
        if (wb_err)      term_status = 2'b01;
        else if (wb_rty) term_status = 2'b10;
    end

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    assign tmo_hit = (17'(tmo_cnt) + 17'd1) == 17'(TIMEOUT);
`else
    logic unused_timeout;
    assign unused_timeout = ^16'(TIMEOUT);
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state      <= IDLE;
            wb_cycle   <= 1'b0;
            wb_strobe  <= 1'b0;
            wb_we      <= 1'b0;
            wb_sel     <= '0;
            wb_addr    <= '0;
            wb_wdata   <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_status <= 2'b00;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        wb_we     <= req_we;
                        wb_addr   <= req_addr;
                        wb_wdata  <= req_wdata;
                        wb_sel    <= req_sel;
                        wb_cycle  <= 1'b1;
                        wb_strobe <= 1'b1;
                        state     <= BUS;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                        tmo_cnt   <= '0;
`endif
                    end
                end
                BUS: begin
                    // A real termination on the expiry edge wins over the timeout.
                    if (term || tmo_hit) begin
                        wb_cycle   <= 1'b0;
                        wb_strobe  <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_status <= term ? term_status : 2'b11;
                        rsp_rdata  <= (wb_ack && !wb_err && !wb_rty && !wb_we) ? wb_rdata : 32'd0;
                        state      <= RESP;
                    end
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                    else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: reset, read/write, terminations, timeout or
// indefinite wait (depending on WB_CMD_MASTER_TIMEOUT_EN), backpressure, mid-bus reset.
module tb_wb_cmd_master;
    localparam int ADDR_W = 8;

    logic              wb_clk = 1'b0;
    logic              wb_rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic [3:0]        req_sel = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_status;
    logic              wb_cycle, wb_strobe, wb_we;
    logic [3:0]        wb_sel;
    logic [ADDR_W-1:0] wb_addr;
    logic [31:0]       wb_wdata;
    logic [2:0]        wb_cti;
    logic [1:0]        wb_bte;
    logic              wb_ack = 1'b0, wb_err = 1'b0, wb_rty = 1'b0;
    logic [31:0]       wb_rdata = '0;
    logic [1:0]        dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [33:0] exp_q[$];

    wb_cmd_master #(.ADDR_W(ADDR_W), .TIMEOUT(4)) dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_status(rsp_status),
        .wb_cycle(wb_cycle), .wb_strobe(wb_strobe), .wb_we(wb_we), .wb_sel(wb_sel),
        .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_cti(wb_cti), .wb_bte(wb_bte),
        .wb_ack(wb_ack), .wb_err(wb_err), .wb_rty(wb_rty), .wb_rdata(wb_rdata),
        .dbg_state(dbg_state)
    );

    // clock/reset block
    always #5 wb_clk = ~wb_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks so far %0d", n_checks);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Driver + scoreboard for one command. term = {err, rty, ack} presented after
    // `waits` wait cycles; hold = cycles of response backpressure with req_valid high.
    task automatic do_txn(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [3:0] sel, input int waits, input logic [2:0] term,
                          input logic [31:0] rdata, input logic [1:0] exp_status,
                          input logic [31:0] exp_rdata, input int hold);
        logic [46:0] bus_exp;
        logic [33:0] exp_rsp;
        bus_exp = {1'b1, 1'b1, we, sel, addr, wdata};
        exp_q.push_back({exp_status, exp_rdata});
        check("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_sel = sel;
        @(posedge wb_clk); #1;
        req_valid = 1'b0;
        for (int k = 0; k <= waits; k++) begin
            if (k == waits) begin
                {wb_err, wb_rty, wb_ack} = term;
                wb_rdata = rdata;
            end
            @(negedge wb_clk);
            check("bus_hold", 64'({wb_cycle, wb_strobe, wb_we, wb_sel, wb_addr, wb_wdata}), 64'(bus_exp));
            check("busy_no_rsp", 64'({req_ready, rsp_valid}), 64'd0);
            @(posedge wb_clk); #1;
        end
        {wb_err, wb_rty, wb_ack} = 3'b000;
        wb_rdata  = 32'h0;
        req_valid = (hold > 0);
        exp_rsp = exp_q.pop_front();
        @(negedge wb_clk);
        check("rsp", 64'({rsp_valid, wb_cycle, wb_strobe, rsp_status, rsp_rdata}),
              64'({1'b1, 1'b0, 1'b0, exp_rsp}));
        for (int h = 0; h < hold; h++) begin
            @(posedge wb_clk); #1;
            @(negedge wb_clk);
            check("rsp_hold", 64'({rsp_valid, req_ready, wb_cycle, rsp_status, rsp_rdata}),
                  64'({1'b1, 1'b0, 1'b0, exp_rsp}));
        end
        rsp_ready = 1'b1;
        @(posedge wb_clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        @(negedge wb_clk);
        check("rsp_done", 64'({rsp_valid, req_ready, wb_cycle}), 64'd2);
        @(posedge wb_clk); #1;
    endtask

    initial begin
        #2;
        check("reset_ctrl", 64'({req_ready, rsp_valid, rsp_status, wb_cycle, wb_strobe, wb_we}), 64'd0);
        check("reset_bus", 64'({wb_sel, wb_addr, wb_wdata, rsp_rdata}), 64'd0);
        check("cti_bte", 64'({wb_cti, wb_bte}), 64'd0);
        repeat (2) @(posedge wb_clk);
        @(negedge wb_clk); #2;
        wb_rst_n = 1'b1;
        #1;
        check("ready_before_sync", 64'(req_ready), 64'd0);
        @(posedge wb_clk); #1;
        check("ready_after_sync", 64'(req_ready), 64'd1);

        // Terminations while idle must not produce anything.
        wb_ack = 1'b1; wb_err = 1'b1;
        repeat (2) begin @(posedge wb_clk); #1; end
        @(negedge wb_clk);
        check("idle_term_ignored", 64'({rsp_valid, wb_cycle, req_ready}), 64'd1);
        wb_ack = 1'b0; wb_err = 1'b0;
        @(posedge wb_clk); #1;

        // read, ack in first bus cycle
        do_txn(1'b0, 8'h10, 32'h0, 4'hF, 0, 3'b001, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF, 0);
        // write, ack after 3 wait cycles, slave rdata must not leak
        do_txn(1'b1, 8'h04, 32'h12345678, 4'hF, 3, 3'b001, 32'hAAAA5555, 2'b00, 32'h0, 0);
        // err and ack together on a read
        do_txn(1'b0, 8'h20, 32'h0, 4'h3, 1, 3'b101, 32'hCAFEF00D, 2'b01, 32'h0, 0);
        // rty alone, response held back for 10 cycles with req_valid high
        do_txn(1'b0, 8'h24, 32'h0, 4'hC, 0, 3'b010, 32'h11112222, 2'b10, 32'h0, 10);
        // rty together with ack
        do_txn(1'b0, 8'h28, 32'h0, 4'h1, 0, 3'b011, 32'h33334444, 2'b10, 32'h0, 0);
        // backpressure on a successful read
        do_txn(1'b0, 8'hFC, 32'h0, 4'h5, 2, 3'b001, 32'h89ABCDEF, 2'b00, 32'h89ABCDEF, 10);
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        // no response: 4 bus cycles then timeout status
        do_txn(1'b0, 8'h30, 32'h0, 4'hF, 3, 3'b000, 32'h0, 2'b11, 32'h0, 0);
        // ack on the expiry edge beats the timeout
        do_txn(1'b0, 8'h34, 32'h0, 4'hF, 3, 3'b001, 32'h5A5A5A5A, 2'b00, 32'h5A5A5A5A, 0);
        // write timeout
        do_txn(1'b1, 8'h38, 32'hFFFF0000, 4'h6, 3, 3'b000, 32'h0, 2'b11, 32'h0, 0);
`else
        // no timeout logic: bus waits well past the TIMEOUT value
        do_txn(1'b0, 8'h30, 32'h0, 4'hF, 20, 3'b001, 32'h5A5A5A5A, 2'b00, 32'h5A5A5A5A, 0);
`endif

        // reset in the 2nd bus cycle
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h40; req_sel = 4'hF;
        @(posedge wb_clk); #1;
        req_valid = 1'b0;
        @(negedge wb_clk);
        check("rst_test_bus", 64'({wb_cycle, wb_strobe}), 64'd3);
        @(posedge wb_clk); #2;
        wb_rst_n = 1'b0;
        #1;
        check("rst_async", 64'({wb_cycle, wb_strobe, rsp_valid, req_ready}), 64'd0);
        check("rst_async_bus", 64'({wb_addr, wb_sel}), 64'd0);
        repeat (2) begin
            @(negedge wb_clk);
            check("rst_no_rsp", 64'({rsp_valid, wb_cycle, req_ready}), 64'd0);
        end
        @(negedge wb_clk); #2;
        wb_rst_n = 1'b1;
        #1;
        check("rst_release_ready", 64'(req_ready), 64'd0);
        @(posedge wb_clk); #1;
        check("rst_no_rsp_after", 64'(rsp_valid), 64'd0);
        do_txn(1'b0, 8'h44, 32'h0, 4'hF, 1, 3'b001, 32'h0BADF00D, 2'b00, 32'h0BADF00D, 0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the Wishbone byte-address width.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of bus cycles to wait for termination (legal range 1..65535).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset; both are listed below.
REQ-004 The block SHALL have port wb_clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port wb_rst_n, input, 1, the asynchronous active-low reset.
REQ-006 The block SHALL have port req_valid, input, 1, the command request.
REQ-007 The block SHALL have port req_ready, output, 1, the command accept.
REQ-008 The block SHALL have ports req_we, input, 1 (1=write); req_addr, input, ADDR_W; req_wdata, input, 32; and req_sel, input, 4.
REQ-009 The block SHALL have port rsp_valid, output, 1, the response available.
REQ-010 The block SHALL have port rsp_ready, input, 1, the response consumed.
REQ-011 The block SHALL have port rsp_rdata, output, 32, the read data.
REQ-012 The block SHALL have port rsp_status, output, 2: 00 ok, 01 err, 10 rty, 11 timeout.
REQ-013 The block SHALL have Wishbone outputs wb_cycle (1), wb_strobe (1), wb_we (1), wb_sel (4), wb_addr (ADDR_W), wb_wdata (32), wb_cti (3) and wb_bte (2).
REQ-014 The block SHALL have Wishbone inputs wb_ack (1), wb_err (1), wb_rty (1) and wb_rdata (32).

Function
REQ-015 The block SHALL implement a Wishbone classic single-cycle master with FSM states IDLE, BUS and RESP.
REQ-016 In IDLE, req_ready SHALL be 1; in BUS and RESP, req_ready SHALL be 0.
REQ-017 On an edge with req_valid and req_ready both high, the block SHALL register we/addr/wdata/sel and go to BUS.
REQ-018 In BUS, wb_cycle and wb_strobe SHALL be 1, and wb_we/wb_addr/wb_wdata/wb_sel SHALL be held stable from the registered values.
REQ-019 All wb_* outputs SHALL be driven from registers; wb_cti SHALL always be 000 and wb_bte SHALL always be 00.
REQ-020 When wb_ack, wb_err or wb_rty is sampled high in BUS, the block SHALL go to RESP; wb_cycle and wb_strobe SHALL be 0 from the following cycle.
REQ-021 Simultaneous terminations SHALL be resolved with priority err > rty > ack.
REQ-022 rsp_rdata SHALL capture wb_rdata only on a read with ack; it SHALL be 0 for writes, err, rty and timeout.
REQ-023 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_status SHALL be stable until rsp_ready is high on an edge; the block then goes to IDLE.
REQ-024 The minimum latency SHALL be: accept at edge N, cyc high in cycle N+1, ack at edge N+1, rsp_valid high at N+2, and next accept possible at N+3 after rsp_ready.
REQ-025 The block SHALL perform no automatic retry; rty SHALL only be reported in rsp_status.
REQ-026 wb_ack, wb_err and wb_rty asserted outside BUS SHALL be ignored.
REQ-027 req_valid SHALL be ignored outside IDLE, and no command SHALL be lost or queued.

Reset
REQ-028 Asserting wb_rst_n low SHALL immediately force IDLE, wb_cycle=0, wb_strobe=0, wb_we=0, wb_sel=0, wb_addr=0, wb_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_status=00 and the timeout counter to 0.
REQ-029 While wb_rst_n is low, req_ready SHALL be 0.
REQ-030 Reset asserted mid-BUS SHALL abandon the transaction with no response.
REQ-031 Reset deassertion SHALL be synchronised internally; the first accept is possible on the second edge after release.

Configuration
REQ-032 With WB_CMD_MASTER_TIMEOUT_EN defined, a 16-bit counter SHALL clear on entry to BUS and increment on each BUS cycle without termination.
REQ-033 With WB_CMD_MASTER_TIMEOUT_EN defined, when the counter reaches TIMEOUT the block SHALL drop cyc/stb, go to RESP and report status 11.
REQ-034 With WB_CMD_MASTER_TIMEOUT_EN defined, a termination sampled on the same edge as expiry SHALL take precedence over the timeout.
REQ-035 Without WB_CMD_MASTER_TIMEOUT_EN, no counter SHALL exist, BUS SHALL wait indefinitely, and status 11 SHALL never occur.

Verification
REQ-036 Read test: req addr=0x10, slave acks in the first BUS cycle with rdata=0xDEADBEEF -> rsp_valid at N+2, rdata=0xDEADBEEF, status=00, cyc low at N+2.
REQ-037 Write test: req we=1, addr=0x04, wdata=0x12345678, sel=0xF, ack after 3 wait cycles -> bus signals stable for 4 cycles, rdata=0, status=00.
REQ-038 Simultaneous termination test: err and ack asserted together -> status=01, rdata=0; rty alone -> status=10, no reissue.
REQ-039 Timeout test (macro defined, TIMEOUT=4): slave never responds -> cyc high exactly 4 cycles then status=11; ack on the 4th cycle -> status=00.
REQ-040 Backpressure test: rsp_ready held low for 10 cycles while req_valid stays high -> req_ready=0 throughout and the response is stable; a single bus cycle occurs.
REQ-041 Reset test: wb_rst_n pulled low in the 2nd BUS cycle -> cyc/stb go to 0 asynchronously, no rsp_valid, and a clean transaction follows after release.
